// File: rtl/pipeline_pkg.sv
// Shared pipeline types: thread index width, thread count and index type.
package pipeline_pkg;

    localparam int THREAD_INDEX_BITS = 3;
    localparam int NUM_THREADS = 2 ** THREAD_INDEX_BITS;

    typedef logic [THREAD_INDEX_BITS-1:0] thread_idx_t;

endpackage

// File: rtl/thread_scheduler_if.sv
// MEM-stage load issue and load response bus seen by the thread scheduler.
interface thread_scheduler_if
    import pipeline_pkg::*;
#(
    parameter int THREAD_INDEX_BITS = pipeline_pkg::THREAD_INDEX_BITS
);

    logic                         mem_issue_valid;
    logic                         mem_issue_load;
    logic [THREAD_INDEX_BITS-1:0] mem_issue_thread;
    logic                         mem_resp_valid;
    logic [THREAD_INDEX_BITS-1:0] mem_resp_thread;

    modport master (
        output mem_issue_valid,
        output mem_issue_load,
        output mem_issue_thread,
        output mem_resp_valid,
        output mem_resp_thread
    );

    modport slave (
        input mem_issue_valid,
        input mem_issue_load,
        input mem_issue_thread,
        input mem_resp_valid,
        input mem_resp_thread
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational rotate-priority search: first set request at or after start.
module rr_priority_picker
    import pipeline_pkg::*;
#(
    parameter int IDX_BITS = pipeline_pkg::THREAD_INDEX_BITS,
    localparam int N = 2 ** IDX_BITS
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] start,
    output logic                valid,
    output logic [IDX_BITS-1:0] index
);

    logic [IDX_BITS-1:0] probe;

    // Walk offsets downward so the smallest offset is the last to win.
    always_comb begin
        valid = 1'b0;
        index = start;
        probe = start;
        for (int i = N - 1; i >= 0; i--) begin
            probe = start + IDX_BITS'(i);
            if (req[probe]) begin
                valid = 1'b1;
                index = probe;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin fetch thread scheduler with load blocking.
// Optional watchdog: define THREAD_SCHED_WATCHDOG_EN.
module thread_scheduler
    import pipeline_pkg::*;
#(
    parameter int THREAD_INDEX_BITS = pipeline_pkg::THREAD_INDEX_BITS,
    parameter int WATCHDOG_CYCLES = 255,
    localparam int NUM_THREADS = 2 ** THREAD_INDEX_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_THREADS-1:0]       thread_enable,
    input  logic                         stall,
    thread_scheduler_if.slave            mem,
    output logic                         issue_valid,
    output logic [THREAD_INDEX_BITS-1:0] issue_thread,
    output logic [NUM_THREADS-1:0]       thread_blocked,
`ifdef THREAD_SCHED_WATCHDOG_EN
    output logic                         timeout_err,
    output logic [THREAD_INDEX_BITS-1:0] timeout_thread,
`endif
    output logic                         idle
);

    logic [THREAD_INDEX_BITS-1:0] last_grant;
    logic [THREAD_INDEX_BITS-1:0] search_start;
    logic [NUM_THREADS-1:0]       eligible;
    logic                         pick_valid;
    logic [THREAD_INDEX_BITS-1:0] pick_idx;
    logic [NUM_THREADS-1:0]       blocked_nxt;

    assign eligible     = thread_enable & ~thread_blocked;
    assign search_start = last_grant + 1'b1;

    rr_priority_picker #(
        .IDX_BITS (THREAD_INDEX_BITS)
    ) u_picker (
        .req   (eligible),
        .start (search_start),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_valid  <= 1'b0;
            issue_thread <= '0;
            idle         <= 1'b1;
            last_grant   <= THREAD_INDEX_BITS'(NUM_THREADS - 1);
        end else if (!stall) begin
            issue_valid <= pick_valid;
            idle        <= ~pick_valid;
            if (pick_valid) begin
                issue_thread <= pick_idx;
                last_grant   <= pick_idx;
            end
        end
    end

`ifdef THREAD_SCHED_WATCHDOG_EN
    localparam int WD_BITS = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(WATCHDOG_CYCLES - 1);

    logic [WD_BITS-1:0]           wd_cnt [NUM_THREADS];
    logic [NUM_THREADS-1:0]       wd_exp;
    logic                         wd_hit;
    logic [THREAD_INDEX_BITS-1:0] wd_idx;

    always_comb begin
        wd_hit = 1'b0;
        wd_idx = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            wd_exp[i] = thread_blocked[i] && (wd_cnt[i] >= WD_LAST);
            if (wd_exp[i]) begin
                wd_hit = 1'b1;
                wd_idx = THREAD_INDEX_BITS'(i);
            end
        end
    end

    // Expired counters saturate so lower-priority timeouts wait their turn.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timeout_err    <= 1'b0;
            timeout_thread <= '0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                wd_cnt[i] <= '0;
            end
        end else begin
            timeout_err <= wd_hit;
            if (wd_hit) begin
                timeout_thread <= wd_idx;
            end
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (!thread_blocked[i]) begin
                    wd_cnt[i] <= '0;
                end else if (wd_hit && wd_idx == THREAD_INDEX_BITS'(i)) begin
                    wd_cnt[i] <= '0;
                end else if (wd_cnt[i] < WD_LAST) begin
                    wd_cnt[i] <= wd_cnt[i] + 1'b1;
                end
            end
        end
    end
`endif

    // Clears first, then the load set so a same-thread set wins.
    always_comb begin
        blocked_nxt = thread_blocked;
`ifdef THREAD_SCHED_WATCHDOG_EN
        if (wd_hit) begin
            blocked_nxt[wd_idx] = 1'b0;
        end
`endif
        if (mem.mem_resp_valid) begin
            blocked_nxt[mem.mem_resp_thread] = 1'b0;
        end
        if (mem.mem_issue_valid && mem.mem_issue_load) begin
            blocked_nxt[mem.mem_issue_thread] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            thread_blocked <= '0;
        end else begin
            thread_blocked <= blocked_nxt;
        end
    end

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed self-checking bench for thread_scheduler.
module tb_thread_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] thread_enable;
    logic       stall;
    logic       issue_valid;
    logic [2:0] issue_thread;
    logic [7:0] thread_blocked;
    logic       idle;
`ifdef THREAD_SCHED_WATCHDOG_EN
    logic       timeout_err;
    logic [2:0] timeout_thread;
`endif

    int checks = 0;
    int failures = 0;

    thread_scheduler_if #(.THREAD_INDEX_BITS(3)) mem_if ();

    thread_scheduler #(
        .THREAD_INDEX_BITS (3),
`ifdef THREAD_SCHED_WATCHDOG_EN
        .WATCHDOG_CYCLES   (16)
`else
        .WATCHDOG_CYCLES   (255)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .thread_enable  (thread_enable),
        .stall          (stall),
        .mem            (mem_if),
        .issue_valid    (issue_valid),
        .issue_thread   (issue_thread),
        .thread_blocked (thread_blocked),
`ifdef THREAD_SCHED_WATCHDOG_EN
        .timeout_err    (timeout_err),
        .timeout_thread (timeout_thread),
`endif
        .idle           (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_idle();
        mem_if.mem_issue_valid  = 1'b0;
        mem_if.mem_issue_load   = 1'b0;
        mem_if.mem_issue_thread = '0;
        mem_if.mem_resp_valid   = 1'b0;
        mem_if.mem_resp_thread  = '0;
    endtask

    task automatic load(input logic [2:0] t);
        mem_if.mem_issue_valid  = 1'b1;
        mem_if.mem_issue_load   = 1'b1;
        mem_if.mem_issue_thread = t;
    endtask

    task automatic resp(input logic [2:0] t);
        mem_if.mem_resp_valid  = 1'b1;
        mem_if.mem_resp_thread = t;
    endtask

    initial begin
        logic [2:0] seq_a [6];
        logic [2:0] seq_b [6];
        seq_a = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5, 3'd7};
        seq_b = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};

        reset = 1'b0;
        thread_enable = '0;
        stall = 1'b0;
        mem_idle();
        step();
        step();
        check("rst_valid", 32'(issue_valid), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_blocked", 32'(thread_blocked), 0);
        check("rst_thread", 32'(issue_thread), 0);

        thread_enable = 8'hFF;
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check("rot_thread", 32'(issue_thread), 32'(i % 8));
            check("rot_valid", 32'(issue_valid), 1);
        end

        thread_enable = 8'b1010_0100;
        for (int i = 0; i < 6; i++) begin
            step();
            check("sparse_thread", 32'(issue_thread), 32'(seq_a[i]));
        end
        check("sparse_idle", 32'(idle), 0);

        thread_enable = 8'hFF;
        load(3'd3);
        step();
        check("ld3_blocked", 32'(thread_blocked), 32'h08);
        check("ld3_grant", 32'(issue_thread), 0);
        mem_idle();
        step();
        step();
        step();
        check("ld3_skip", 32'(issue_thread), 4);
        resp(3'd3);
        step();
        check("rsp3_blocked", 32'(thread_blocked), 0);
        check("rsp3_grant", 32'(issue_thread), 5);
        mem_idle();
        for (int i = 0; i < 6; i++) begin
            step();
            check("rsp3_rot", 32'(issue_thread), 32'(seq_b[i]));
        end

        load(3'd6);
        step();
        check("ld6", 32'(thread_blocked), 32'h40);
        load(3'd4);
        resp(3'd4);
        step();
        check("same_thr_set_wins", 32'(thread_blocked), 32'h50);
        load(3'd4);
        resp(3'd6);
        step();
        check("diff_thr_both", 32'(thread_blocked), 32'h10);
        mem_idle();
        mem_if.mem_issue_valid  = 1'b1;
        mem_if.mem_issue_thread = 3'd2;
        resp(3'd1);
        step();
        check("store_and_stray_rsp", 32'(thread_blocked), 32'h10);
        mem_idle();
        resp(3'd4);
        step();
        check("rsp4", 32'(thread_blocked), 0);
        mem_idle();

        stall = 1'b1;
        reset = 1'b0;
        load(3'd5);
        step();
        check("rst_ovr_valid", 32'(issue_valid), 0);
        check("rst_ovr_idle", 32'(idle), 1);
        check("rst_ovr_blocked", 32'(thread_blocked), 0);
        check("rst_ovr_thread", 32'(issue_thread), 0);
        stall = 1'b0;
        reset = 1'b1;
        mem_idle();
        for (int i = 0; i < 6; i++) begin
            step();
            check("pre_stall", 32'(issue_thread), 32'(i));
        end

        stall = 1'b1;
        load(3'd1);
        step();
        check("stall_hold1", 32'(issue_thread), 5);
        check("stall_blk_upd", 32'(thread_blocked), 32'h02);
        mem_idle();
        step();
        step();
        check("stall_hold3", 32'(issue_thread), 5);
        check("stall_valid", 32'(issue_valid), 1);
        check("stall_idle", 32'(idle), 0);
        stall = 1'b0;
        step();
        check("post_stall", 32'(issue_thread), 6);
        step();
        step();
        step();
        check("skip1", 32'(issue_thread), 2);

        thread_enable = 8'h00;
        step();
        check("idle_valid", 32'(issue_valid), 0);
        check("idle_idle", 32'(idle), 1);
        check("dis_keep_blk", 32'(thread_blocked), 32'h02);
        step();
        thread_enable = 8'hFF;
        step();
        check("hold_last", 32'(issue_thread), 3);

`ifdef THREAD_SCHED_WATCHDOG_EN
        begin
            int pulses;
            logic [2:0] tthr;
            pulses = 0;
            tthr = '0;
            reset = 1'b0;
            step();
            reset = 1'b1;
            load(3'd1);
            step();
            mem_idle();
            for (int i = 0; i < 40; i++) begin
                step();
                if (timeout_err) begin
                    pulses++;
                    tthr = timeout_thread;
                end
            end
            check("wd_pulses", 32'(pulses), 1);
            check("wd_thread", 32'(tthr), 1);
            check("wd_unblock", 32'(thread_blocked), 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
